cellrv32_cpu_cp_fpu32_i2f: RTL and testbench



---
 rtl/cellrv32_cpu_cp_fpu32_i2f.sv | 190 +++++++++++++++++++
 tb/tb_cellrv32_cpu_cp_fpu32_i2f.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_cpu_cp_fpu32_i2f.sv
// Multi-cycle int32/uint32 to binary32 converter (FCVT.S.W / FCVT.S.WU).
// Define CELLRV32_FPU_I2F_FAST_NORM_EN to replace the bit-serial normalizer with an LZC + barrel shift.
module cellrv32_cpu_cp_fpu32_i2f #(
    parameter int XLEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       rmode_i,
    input  logic             funct_i,
    input  logic [XLEN-1:0]  data_i,
    output logic [31:0]      result_o,
    output logic [4:0]       flags_o,
    output logic             done_o
);

    localparam int FP_EXC_NV_C = 0;
    localparam int FP_EXC_DZ_C = 1;
    localparam int FP_EXC_OF_C = 2;
    localparam int FP_EXC_UF_C = 3;
    localparam int FP_EXC_NX_C = 4;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [7:0] EXP_BASE = 8'd158;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_NORMALIZE,
        S_ROUND,
        S_FINALIZE
    } state_t;

    state_t state, state_nxt;

    logic [31:0] data_r;
    logic        funct_r;
    logic [2:0]  rmode_r;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [7:0]  exp_r;
    logic        zero_r;
    logic [22:0] mant_r;
    logic        nx_r;

    logic [31:0] mag_prep;
    logic        sign_prep;
    logic        g_bit, r_bit, st_bit;
    logic        inc;
    logic [24:0] sum;

`ifdef CELLRV32_FPU_I2F_FAST_NORM_EN
    logic [4:0] lzc_r;

    function automatic logic [4:0] lzc32(input logic [31:0] v);
        logic [4:0] n;
        n = 5'd0;
        // Highest set bit wins because later iterations overwrite earlier ones.
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 5'(31 - i);
        end
        return n;
    endfunction
`endif

    // Two's-complement negation of 0x80000000 yields itself, which is the correct magnitude.
    always_comb begin
        sign_prep = ~funct_r & data_r[31];
        mag_prep  = sign_prep ? (32'd0 - data_r) : data_r;
    end

    always_comb begin
        g_bit  = mag_r[7];
        r_bit  = mag_r[6];
        st_bit = |mag_r[5:0];
        inc    = 1'b0;
        case (rmode_r)
            RM_RNE:  inc = g_bit & (r_bit | st_bit | mag_r[8]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_r & (g_bit | r_bit | st_bit);
            RM_RUP:  inc = ~sign_r & (g_bit | r_bit | st_bit);
            RM_RMM:  inc = g_bit;
            default: inc = 1'b0;
        endcase
        sum = {1'b0, 1'b1, mag_r[30:8]} + {24'd0, inc};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start_i) state_nxt = S_PREPARE;
            S_PREPARE:   state_nxt = (mag_prep == 32'd0) ? S_FINALIZE : S_NORMALIZE;
`ifdef CELLRV32_FPU_I2F_FAST_NORM_EN
            S_NORMALIZE: state_nxt = S_ROUND;
`else
            S_NORMALIZE: if (mag_r[31]) state_nxt = S_ROUND;
`endif
            S_ROUND:     state_nxt = S_FINALIZE;
            S_FINALIZE:  state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r   <= '0;
            funct_r  <= 1'b0;
            rmode_r  <= '0;
            sign_r   <= 1'b0;
            mag_r    <= '0;
            exp_r    <= '0;
            zero_r   <= 1'b0;
            mant_r   <= '0;
            nx_r     <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
            done_o   <= 1'b0;
`ifdef CELLRV32_FPU_I2F_FAST_NORM_EN
            lzc_r    <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        data_r  <= data_i;
                        funct_r <= funct_i;
                        rmode_r <= rmode_i;
                    end
                end
                S_PREPARE: begin
                    sign_r <= sign_prep;
                    mag_r  <= mag_prep;
                    exp_r  <= EXP_BASE;
                    zero_r <= (mag_prep == 32'd0);
                    nx_r   <= 1'b0;
`ifdef CELLRV32_FPU_I2F_FAST_NORM_EN
                    lzc_r  <= lzc32(mag_prep);
`endif
                end
                S_NORMALIZE: begin
`ifdef CELLRV32_FPU_I2F_FAST_NORM_EN
                    mag_r <= mag_r << lzc_r;
                    exp_r <= EXP_BASE - {3'd0, lzc_r};
`else
                    if (!mag_r[31]) begin
                        mag_r <= {mag_r[30:0], 1'b0};
                        exp_r <= exp_r - 8'd1;
                    end
`endif
                end
                S_ROUND: begin
                    // Carry-out means the mantissa wrapped to 1.0; exponent tops out at 159.
                    if (sum[24]) begin
                        mant_r <= '0;
                        exp_r  <= exp_r + 8'd1;
                    end else begin
                        mant_r <= sum[22:0];
                    end
                    nx_r <= g_bit | r_bit | st_bit;
                end
                S_FINALIZE: begin
                    result_o <= zero_r ? 32'd0 : {sign_r, exp_r, mant_r};
                    flags_o  <= '0;
                    flags_o[FP_EXC_NX_C] <= nx_r & ~zero_r;
                    flags_o[FP_EXC_NV_C] <= 1'b0;
                    flags_o[FP_EXC_DZ_C] <= 1'b0;
                    flags_o[FP_EXC_OF_C] <= 1'b0;
                    flags_o[FP_EXC_UF_C] <= 1'b0;
                    done_o   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu32_i2f.sv
// Directed-vector bench for cellrv32_cpu_cp_fpu32_i2f (result, flags, latency, reset abort, back-to-back).
module tb_cellrv32_cpu_cp_fpu32_i2f;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  rmode;
    logic        funct;
    logic [31:0] data;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        done;

    int n_total;
    int n_pass;

    cellrv32_cpu_cp_fpu32_i2f #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .rmode_i  (rmode),
        .funct_i  (funct),
        .data_i   (data),
        .result_o (result),
        .flags_o  (flags),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        funct;
        logic [2:0]  rmode;
        logic [31:0] data;
        logic [31:0] exp_res;
        logic [4:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int lat_of(input int iter_lat);
`ifdef CELLRV32_FPU_I2F_FAST_NORM_EN
        return (iter_lat > 2) ? 4 : iter_lat;
`else
        return iter_lat;
`endif
    endfunction

    // Returns with the bench sitting 1 time unit after the edge that raised done (or after timeout).
    task automatic do_op(input logic f, input logic [2:0] rm, input logic [31:0] d, input bit sync,
                         output logic [31:0] res, output logic [4:0] fl, output int lat);
        if (sync) @(negedge clk);
        start = 1'b1;
        funct = f;
        rmode = rm;
        data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = $urandom;
        funct = 1'($urandom_range(0, 1));
        rmode = 3'($urandom_range(0, 7));
        lat   = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        fl  = flags;
    endtask

    task automatic add(input string n, input logic f, input logic [2:0] rm, input logic [31:0] d,
                       input logic [31:0] r, input logic [4:0] fl, input int lat);
        vec_t v;
        v.name = n; v.funct = f; v.rmode = rm; v.data = d;
        v.exp_res = r; v.exp_flags = fl; v.exp_lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        int          seen;

        n_total = 0;
        n_pass  = 0;
        start = 1'b0; funct = 1'b0; rmode = 3'd0; data = 32'd0;

        add("s1_rne",        1'b0, 3'b000, 32'h00000001, 32'h3F800000, 5'h00, 35);
        add("sm1_rne",       1'b0, 3'b000, 32'hFFFFFFFF, 32'hBF800000, 5'h00, 35);
        add("z_s_rne",       1'b0, 3'b000, 32'h00000000, 32'h00000000, 5'h00, 2);
        add("z_u_rtz",       1'b1, 3'b001, 32'h00000000, 32'h00000000, 5'h00, 2);
        add("z_s_rdn",       1'b0, 3'b010, 32'h00000000, 32'h00000000, 5'h00, 2);
        add("z_u_rup",       1'b1, 3'b011, 32'h00000000, 32'h00000000, 5'h00, 2);
        add("z_s_rmm",       1'b0, 3'b100, 32'h00000000, 32'h00000000, 5'h00, 2);
        add("smax_rne",      1'b0, 3'b000, 32'h7FFFFFFF, 32'h4F000000, 5'h10, 5);
        add("smax_rtz",      1'b0, 3'b001, 32'h7FFFFFFF, 32'h4EFFFFFF, 5'h10, 5);
        add("smin_s",        1'b0, 3'b000, 32'h80000000, 32'hCF000000, 5'h00, 4);
        add("smin_u",        1'b1, 3'b000, 32'h80000000, 32'h4F000000, 5'h00, 4);
        add("umax_rup",      1'b1, 3'b011, 32'hFFFFFFFF, 32'h4F800000, 5'h10, 4);
        add("umax_rdn",      1'b1, 3'b010, 32'hFFFFFFFF, 32'h4F7FFFFF, 5'h10, 4);
        add("umax_rm5",      1'b1, 3'b101, 32'hFFFFFFFF, 32'h4F7FFFFF, 5'h10, 4);
        add("tie_rne",       1'b1, 3'b000, 32'h01000001, 32'h4B800000, 5'h10, 11);
        add("tie_rmm",       1'b1, 3'b100, 32'h01000001, 32'h4B800001, 5'h10, 11);
        add("neg_tie_rdn",   1'b0, 3'b010, 32'hFEFFFFFF, 32'hCB800001, 5'h10, 11);
        add("neg_tie_rup",   1'b0, 3'b011, 32'hFEFFFFFF, 32'hCB800000, 5'h10, 11);
        add("exact_1000",    1'b0, 3'b000, 32'd1000,     32'h447A0000, 5'h00, 26);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_flags",  {27'd0, flags}, 32'h0);
        chk("reset_done",   {31'd0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].funct, vecs[i].rmode, vecs[i].data, 1'b1, res, fl, lat);
            chk({vecs[i].name, "_res"},   res, vecs[i].exp_res);
            chk({vecs[i].name, "_flags"}, {27'd0, fl}, {27'd0, vecs[i].exp_flags});
            chk({vecs[i].name, "_lat"},   32'(lat), 32'(lat_of(vecs[i].exp_lat)));
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_pulse"}, {31'd0, done}, 32'h0);
            chk({vecs[i].name, "_hold"},  result, vecs[i].exp_res);
        end

        // Abort a long conversion mid-normalize; outputs clear and no done appears.
        @(negedge clk);
        start = 1'b1; funct = 1'b0; rmode = 3'b000; data = 32'h00000001;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_result", result, 32'h0);
        chk("abort_flags",  {27'd0, flags}, 32'h0);
        chk("abort_done",   {31'd0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'h0);
        do_op(1'b0, 3'b001, 32'h7FFFFFFF, 1'b1, res, fl, lat);
        chk("after_abort_res",   res, 32'h4EFFFFFF);
        chk("after_abort_flags", {27'd0, fl}, 32'h10);

        // Start pulses while busy must not disturb the running conversion.
        @(negedge clk);
        start = 1'b1; funct = 1'b1; rmode = 3'b100; data = 32'h01000001;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; funct = 1'b0; rmode = 3'b001; data = 32'h00000000;
            @(negedge clk);
            lat++;
            start = 1'b0;
        end
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            if (!done) begin
                @(negedge clk);
                lat++;
            end
        end
        chk("busy_res",   result, 32'h4B800001);
        chk("busy_flags", {27'd0, flags}, 32'h10);

        // Back-to-back: start raised in the cycle done is high.
        do_op(1'b0, 3'b000, 32'hFFFFFFFF, 1'b1, res, fl, lat);
        chk("b2b_first_res", res, 32'hBF800000);
        do_op(1'b0, 3'b000, 32'h80000000, 1'b0, res, fl, lat);
        chk("b2b_second_res", res, 32'hCF000000);
        chk("b2b_second_lat", 32'(lat), 32'(lat_of(4)));
        do_op(1'b1, 3'b000, 32'h00000000, 1'b0, res, fl, lat);
        chk("b2b_zero_res",   res, 32'h0);
        chk("b2b_zero_flags", {27'd0, fl}, 32'h0);
        chk("b2b_zero_lat",   32'(lat), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
